// File: rtl/jk_seq_pkg.sv
// jk_seq_pkg: shared types and constants for the JK stimulus sequencer.
package jk_seq_pkg;

   // Width of the hold field stored in each step-table entry.
   localparam int SEQ_HW = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // JK codes as seen by the downstream flop, {J,K}.
   localparam logic [1:0] JK_HOLD = 2'b00;
   localparam logic [1:0] JK_RST  = 2'b01;
   localparam logic [1:0] JK_SET  = 2'b10;
   localparam logic [1:0] JK_TGL  = 2'b11;

   typedef struct packed {
      logic [1:0]        jk;
      logic [SEQ_HW-1:0] hold;
   } step_t;

endpackage

// File: rtl/jk_seq_model.sv
// jk_seq_model: reference model of the downstream JK flop. Tracks the expected
// q (qm) from the applied JK code and raises a sticky mismatch flag when the
// observed q disagrees. The model only becomes trusted after the first
// explicit set or reset, because the real flop powers up unknown.
import jk_seq_pkg::*;

module jk_seq_model (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       clr_i,
   input  logic [1:0] jk_i,
   input  logic       q_obs_i,
   output logic       mismatch_o
);

   logic qm_q, qm_d;
   logic mv_q, mv_d;
   logic mis_q, mis_d;

   // Next model state: JK truth table, validity tracking and sticky compare.
   always_comb begin
      qm_d  = qm_q;
      mv_d  = mv_q | (jk_i == JK_RST) | (jk_i == JK_SET);
      mis_d = mis_q | (mv_q & (q_obs_i != qm_q));
      case (jk_i)
         JK_RST:  qm_d = 1'b0;
         JK_SET:  qm_d = 1'b1;
         JK_TGL:  qm_d = ~qm_q;
         default: qm_d = qm_q;
      endcase
      if (clr_i) begin
         mv_d  = 1'b0;
         mis_d = 1'b0;
      end
   end

   // Model registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         qm_q  <= 1'b0;
         mv_q  <= 1'b0;
         mis_q <= 1'b0;
      end else begin
         qm_q  <= qm_d;
         mv_q  <= mv_d;
         mis_q <= mis_d;
      end
   end

   assign mismatch_o = mis_q;

endmodule

// File: rtl/jk_seq_gen.sv
// jk_seq_gen: programmable JK stimulus sequencer feeding a JK flop.
// Plays steps 0..last of a small (jk, hold) table, each lasting hold+1 cycles,
// once or looped, with start/busy/done handshake and abort.
// Optional q checker enabled by defining JK_SEQ_QCHK_EN.
import jk_seq_pkg::*;

module jk_seq_gen #(
   parameter int NSTEPS = 4,
   parameter int AW     = 2,
   parameter int HW     = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cfg_we,
   input  logic [AW-1:0] cfg_addr,
   input  logic [1:0]    cfg_jk,
   input  logic [HW-1:0] cfg_hold,
   input  logic [AW-1:0] cfg_last,
   input  logic          loop,
   input  logic          start,
   input  logic          abort,
   input  logic          q_obs,
   output logic [1:0]    JK,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] step_idx,
   output logic          mismatch
);

   state_e        state_q, state_d;
   logic [AW-1:0] step_q, step_d, step_nx;
   logic [HW-1:0] cnt_q, cnt_d;
   logic [1:0]    jk_q, jk_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [AW-1:0] last_q, last_d;
   logic          loop_q, loop_d;
   logic          start_acc;
   step_t         tbl_q [NSTEPS];

   // Next-state and registered-output logic of the sequencer FSM.
   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      cnt_d     = cnt_q;
      jk_d      = jk_q;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      last_d    = last_q;
      loop_d    = loop_q;
      start_acc = 1'b0;
      step_nx   = step_q + AW'(1);
      case (state_q)
         IDLE: begin
            jk_d = JK_HOLD;
            if (start && !abort) begin
               start_acc = 1'b1;
               last_d    = cfg_last;
               loop_d    = loop;
               state_d   = RUN;
               step_d    = '0;
               jk_d      = tbl_q[0].jk;
               cnt_d     = HW'(tbl_q[0].hold);
               busy_d    = 1'b1;
            end
         end
         RUN: begin
            if (abort) begin
               state_d = IDLE;
               jk_d    = JK_HOLD;
               step_d  = '0;
               cnt_d   = '0;
            end else if (cnt_q != '0) begin
               cnt_d  = cnt_q - HW'(1);
               busy_d = 1'b1;
            end else if (step_q != last_q) begin
               step_d = step_nx;
               jk_d   = tbl_q[step_nx].jk;
               cnt_d  = HW'(tbl_q[step_nx].hold);
               busy_d = 1'b1;
            end else if (loop_q) begin
               // Wrap straight back to entry 0 so the pattern has no gap.
               step_d = '0;
               jk_d   = tbl_q[0].jk;
               cnt_d  = HW'(tbl_q[0].hold);
               busy_d = 1'b1;
            end else begin
               state_d = DONE;
               jk_d    = JK_HOLD;
               done_d  = 1'b1;
            end
         end
         DONE: begin
            jk_d    = JK_HOLD;
            state_d = IDLE;
         end
         default: begin
            jk_d    = JK_HOLD;
            state_d = IDLE;
         end
      endcase
   end

   // Sequencer state and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         step_q  <= '0;
         cnt_q   <= '0;
         jk_q    <= JK_HOLD;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         last_q  <= '0;
         loop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         cnt_q   <= cnt_d;
         jk_q    <= jk_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         last_q  <= last_d;
         loop_q  <= loop_d;
      end
   end

   // Step table; frozen while a sequence is running so playback is stable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NSTEPS; i++) tbl_q[i] <= '0;
      end else if (cfg_we && state_q != RUN) begin
         tbl_q[cfg_addr] <= {cfg_jk, SEQ_HW'(cfg_hold)};
      end
   end

   assign JK       = jk_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign step_idx = step_q;

`ifdef JK_SEQ_QCHK_EN
   jk_seq_model u_model (
      .clk_i      (clk),
      .rst_i      (rst),
      .clr_i      (start_acc),
      .jk_i       (jk_q),
      .q_obs_i    (q_obs),
      .mismatch_o (mismatch)
   );
`else
   logic unused_chk;
   assign unused_chk = ^{q_obs, start_acc};
   assign mismatch   = 1'b0;
`endif

endmodule
